lcd_text_scroller: RTL and testbench

Upstream content stage for the 16x2 character LCD driver. Holds a message buffer written by the host logic and renders a two-line marquee into the 256-bit `chars` frame. The LCD driver consumes that frame: line 1 in `chars[255:128]`, line 2 in `chars[127:0]`, and character i of a line in bits `[top - 8*i -: 8]`. The window scrolls one character every `STEP_TICKS` rising edges of the shared `tick` strobe, and each new frame is published atomically so the driver never sees a torn frame.

---
 rtl/lcd_text_scroller.sv | 182 ++++++++++++++++++
 tb/tb_lcd_text_scroller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_scroller.sv
// lcd_text_scroller: message buffer plus marquee renderer for the 16x2 LCD
// driver. A fill walks 32 buffer bytes into a shadow frame starting at the
// scroll offset, then publishes the shadow to `chars` in one step.
//
// Output handshake: `chars_valid` is a valid-only strobe (the driver has no
// ready). It is high for exactly one cycle, in the cycle `chars` first shows
// a new frame; `chars` never changes outside such a cycle.
module lcd_text_scroller #(
  parameter int MAX_LEN    = 64,
  parameter int STEP_TICKS = 25,
  localparam int AW        = $clog2(MAX_LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           en,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [7:0]     wr_data,
  input  logic [AW:0]    msg_len,
  output logic [255:0]   chars,
  output logic           chars_valid,
  output logic           busy,
  output logic [AW-1:0]  pos,
  output logic [1:0]     state_dbg
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_TICKS - 1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(MAX_LEN);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);
  localparam logic [255:0]  SPACES    = {32{8'h20}};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PUB} state_t;

  state_t          state;
  logic [CW-1:0]   step_cnt;
  logic            tick_d;
  logic            dirty;
  logic [AW:0]     msg_len_q;
  logic [AW:0]     len_r;
  logic [AW-1:0]   idx;
  logic [4:0]      k;
  logic [7:0]      mem [MAX_LEN];
  logic [7:0]      rd_q;
  logic [4:0]      wk_q;
  logic            wv_q;
  logic [255:0]    shadow;
  logic            pub_q;

  logic            tick_rise;
  logic            step_adv;
  logic            dirty_set;
  logic [AW:0]     len_c;
  logic [AW:0]     pos_inc;
  logic [AW:0]     idx_inc;
  logic [AW-1:0]   pos_step;
  logic [AW-1:0]   idx_start;
  logic [AW-1:0]   idx_next;
  logic [7:0]      sh_top;

  assign state_dbg = state;

  // Step, wrap and clamp arithmetic; wraps use compares, never a divider.
  assign tick_rise = tick & ~tick_d;
  assign step_adv  = en & tick_rise & (step_cnt == STEP_LAST);
  assign dirty_set = wr_en | (msg_len != msg_len_q) | step_adv;
  assign len_c     = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign pos_inc   = {1'b0, pos} + ONE;
  assign idx_inc   = {1'b0, idx} + ONE;
  assign pos_step  = (pos_inc >= len_r) ? '0 : pos_inc[AW-1:0];
  assign idx_start = ({1'b0, pos} < len_c) ? pos : '0;
  assign idx_next  = (idx_inc == len_r) ? '0 : idx_inc[AW-1:0];
  assign sh_top    = 8'd255 - {wk_q, 3'b000};

  // Tick edge detect and the scroll step prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d   <= 1'b0;
      step_cnt <= '0;
    end else begin
      tick_d <= tick;
      if (en && tick_rise) begin
        if (step_cnt == STEP_LAST) step_cnt <= '0;
        else                       step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // Pending-refresh flag; new triggers win over the IDLE consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty     <= 1'b1;
      msg_len_q <= '0;
    end else begin
      msg_len_q <= msg_len;
      if (dirty_set)                      dirty <= 1'b1;
      else if (state == S_IDLE && dirty)  dirty <= 1'b0;
    end
  end

  // Message buffer; writes are accepted in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 8'h20;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Control FSM: IDLE -> FILL (32 reads) -> PUB, plus the scroll offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len_r <= '0;
      idx   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      pos   <= '0;
      pub_q <= 1'b0;
    end else begin
      pub_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dirty) begin
            len_r <= len_c;
            idx   <= idx_start;
            k     <= '0;
            busy  <= 1'b1;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          idx <= idx_next;
          k   <= k + 5'd1;
          if (k == 5'd31) state <= S_PUB;
        end
        S_PUB: begin
          busy  <= 1'b0;
          pub_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A step in the same cycle as the fill start takes precedence; its
      // dirty set guarantees a follow-up fill at the new offset.
      if (step_adv)                     pos <= pos_step;
      else if (state == S_IDLE && dirty) pos <= idx_start;
    end
  end

  // Registered buffer read; a same-cycle write to idx returns the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 8'h20;
      wk_q <= '0;
      wv_q <= 1'b0;
    end else begin
      rd_q <= (len_r == '0) ? 8'h20 : mem[idx];
      wk_q <= k;
      wv_q <= (state == S_FILL);
    end
  end

  // Shadow frame assembly: frame byte k lives at bits [255-8k -: 8].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shadow <= SPACES;
    else if (wv_q) shadow[sh_top -: 8] <= rd_q;
  end

  // Atomic publish of the completed shadow frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chars       <= SPACES;
      chars_valid <= 1'b0;
    end else begin
      chars_valid <= pub_q;
      if (pub_q) chars <= shadow;
    end
  end

endmodule

// File: tb/tb_lcd_text_scroller.sv
// Directed/randomized bench for lcd_text_scroller with a frame-level model.
module tb_lcd_text_scroller;
  localparam int MAX_LEN    = 64;
  localparam int STEP_TICKS = 2;
  localparam logic [255:0] SPACES = {32{8'h20}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         en = 1'b0;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic [6:0]   msg_len = '0;
  logic [255:0] chars;
  logic         chars_valid;
  logic         busy;
  logic [5:0]   pos;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid_seen = 0;

  logic [7:0]   mem_m [MAX_LEN];
  int           pos_m;
  int           step_m;
  logic [255:0] exp_q [$];

  lcd_text_scroller #(.MAX_LEN(MAX_LEN), .STEP_TICKS(STEP_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .chars(chars), .chars_valid(chars_valid), .busy(busy), .pos(pos),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (chars_valid) n_valid_seen++;

  // reference model
  function automatic int len_m();
    return (int'(msg_len) > MAX_LEN) ? MAX_LEN : int'(msg_len);
  endfunction

  function automatic logic [255:0] model_frame();
    logic [255:0] f;
    int len;
    len = len_m();
    for (int c = 0; c < 32; c++)
      f[255 - 8*c -: 8] = (len == 0) ? 8'h20 : mem_m[(pos_m + c) % len];
    return f;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < MAX_LEN; i++) mem_m[i] = 8'h20;
    pos_m  = 0;
    step_m = 0;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input int addr, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic set_len(input int v);
    int len;
    @(negedge clk);
    msg_len = 7'(v);
    len = len_m();
    if (pos_m >= len) pos_m = 0;
  endtask

  task automatic tick_pulse(input int gap);
    int len;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (gap) @(negedge clk);
    if (en) begin
      if (step_m == STEP_TICKS - 1) begin
        step_m = 0;
        len = len_m();
        pos_m = (len == 0) ? 0 : (pos_m + 1) % len;
      end else begin
        step_m++;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (chars_valid || busy) quiet = 0;
      else quiet++;
      if (quiet >= 40) done = 1'b1;
    end
    check({tag, "_quiet"}, 256'(done), 256'(1));
  endtask

  task automatic wait_busy(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) done = 1'b1;
    end
    check({tag, "_busy"}, 256'(done), 256'(1));
  endtask

  // Counts negedges until chars_valid (bounded), then checks the pulse width.
  task automatic wait_valid(input string tag, output int cyc);
    bit done;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (chars_valid) done = 1'b1;
    end
    check({tag, "_seen"}, 256'(done), 256'(1));
    @(negedge clk);
    check({tag, "_width"}, 256'(chars_valid), 256'(0));
  endtask

  initial begin
    int cyc;
    int nsteps;
    int a;
    int v0;
    logic [7:0] nd;

    // reset state
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_chars", chars, SPACES);
    check("rst_valid", 256'(chars_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_pos", 256'(pos), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    wait_valid("rst_frame", cyc);
    check("rst_latency", 256'(cyc), 256'(35));
    check("rst_frame", chars, SPACES);

    // HELLO, length 5
    wr(0, "H"); wr(1, "E"); wr(2, "L"); wr(3, "L"); wr(4, "O");
    set_len(5);
    wait_quiet("hello");
    check("hello_line1", chars[255:128], "HELLOHELLOHELLOH");
    check("hello_line2", chars[127:0], "ELLOHELLOHELLOHE");
    check("hello_model", chars, model_frame());

    // scrolling with en high, then frozen with en low
    en = 1'b1;
    tick_pulse(2); tick_pulse(2);
    check("step_pos1", 256'(pos), 256'(pos_m));
    check("step_pos1_const", 256'(pos), 256'(1));
    tick_pulse(2); tick_pulse(2);
    check("step_pos2", 256'(pos), 256'(2));
    wait_quiet("step");
    check("step_line1", chars[255:216], "LLOHE");
    check("step_model", chars, model_frame());
    en = 1'b0;
    v0 = n_valid_seen;
    for (int i = 0; i < 4; i++) tick_pulse(3);
    repeat (40) @(negedge clk);
    check("hold_pos", 256'(pos), 256'(2));
    check("hold_no_frame", 256'(n_valid_seen - v0), 256'(0));

    // 32-byte message, wrap from 31 to 0
    set_len(32);
    for (int i = 0; i < 32; i++) wr(i, 8'($urandom_range(33, 126)));
    wait_quiet("len32");
    check("len32_model", chars, model_frame());
    en = 1'b1;
    while (pos_m != 31) tick_pulse($urandom_range(0, 3));
    wait_quiet("len32_31");
    check("len32_pos31", 256'(pos), 256'(31));
    check("len32_c0", chars[255:248], mem_m[31]);
    check("len32_c1", chars[247:240], mem_m[0]);
    check("len32_31_model", chars, model_frame());
    tick_pulse(1); tick_pulse(1);
    check("len32_wrap_pos", 256'(pos), 256'(0));
    wait_quiet("len32_wrap");
    check("len32_wrap_model", chars, model_frame());

    // zero length, then clamp of an oversized length
    set_len(0);
    wait_quiet("len0");
    check("len0_frame", chars, SPACES);
    check("len0_pos", 256'(pos), 256'(0));
    tick_pulse(1); tick_pulse(1);
    wait_quiet("len0_step");
    check("len0_step_pos", 256'(pos), 256'(0));
    set_len(100);
    for (int i = 0; i < 24; i++) wr($urandom_range(0, 63), 8'($urandom_range(33, 126)));
    wait_quiet("len100");
    check("len100_model", chars, model_frame());
    while (pos_m != 50) tick_pulse($urandom_range(0, 3));
    wait_quiet("len100_50");
    check("len100_pos", 256'(pos), 256'(pos_m));
    check("len100_wrap_model", chars, model_frame());

    // write during FILL: old data now, merged refill 34 cycles later
    a = (pos_m + 40) % MAX_LEN;
    wr(a, 8'($urandom_range(33, 126)));
    exp_q.push_back(model_frame());
    wait_busy("midfill");
    repeat (10) @(negedge clk);
    nd = mem_m[pos_m] ^ 8'h5A;
    wr(pos_m, nd);
    exp_q.push_back(model_frame());
    wait_valid("midfill_f1", cyc);
    check("midfill_f1", chars, exp_q.pop_front());
    wait_valid("midfill_f2", cyc);
    check("midfill_gap", 256'(cyc + 1), 256'(34));
    check("midfill_f2", chars, exp_q.pop_front());

    // reset in the middle of a fill
    wait_quiet("rstfill_pre");
    wr($urandom_range(0, 63), 8'($urandom_range(33, 126)));
    wait_busy("rstfill");
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    @(negedge clk);
    check("rstfill_chars", chars, SPACES);
    check("rstfill_busy", 256'(busy), 256'(0));
    check("rstfill_valid", 256'(chars_valid), 256'(0));
    check("rstfill_pos", 256'(pos), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    wait_valid("rstfill_frame", cyc);
    check("rstfill_latency", 256'(cyc), 256'(35));
    check("rstfill_frame", chars, model_frame());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
